// File: rtl/vortex_mem_line_serializer_pkg.sv
// Shared types and helpers for the Vortex line-to-word serializer.
package vortex_mem_serializer_pkg;

  localparam int BEATS      = 16;
  localparam int WORD_BYTES = 4;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int MEM_ADDR_W = 26;
  localparam int BUS_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Byte address of word b of a line: base + {line, b, 2'b00}, wrapping at the bus width.
  function automatic logic [BUS_ADDR_W-1:0] beat_addr(
    input logic [BUS_ADDR_W-1:0] base,
    input logic [MEM_ADDR_W-1:0] line_addr,
    input logic [BEAT_W-1:0]     b
  );
    beat_addr = base + {line_addr, b, 2'b00};
  endfunction

endpackage

// File: rtl/vortex_mem_line_serializer_if.sv
// Vortex line request/response port plus the 32-bit generic bus manager port of the serializer.
// Handshake: a request transfers on mem_req_valid & mem_req_ready; a response transfers on mem_rsp_valid & mem_rsp_ready, with valid and payload held stable until it does; a bus beat completes on (bus_ren | bus_wen) & !bus_request_stall and is held unchanged while stalled.
interface vortex_mem_line_serializer_if #(
  parameter int LINE_WIDTH     = 512,
  parameter int WORD_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int MEM_TAG_WIDTH  = 56,
  parameter int BUS_ADDR_WIDTH = 32
);
  logic                      mem_req_valid;
  logic                      mem_req_rw;
  logic [LINE_WIDTH/8-1:0]   mem_req_byteen;
  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr;
  logic [LINE_WIDTH-1:0]     mem_req_data;
  logic [MEM_TAG_WIDTH-1:0]  mem_req_tag;
  logic                      mem_req_ready;

  logic                      mem_rsp_valid;
  logic [LINE_WIDTH-1:0]     mem_rsp_data;
  logic [MEM_TAG_WIDTH-1:0]  mem_rsp_tag;
  logic                      mem_rsp_ready;

  logic                      bus_ren;
  logic                      bus_wen;
  logic [BUS_ADDR_WIDTH-1:0] bus_addr;
  logic [WORD_WIDTH-1:0]     bus_wdata;
  logic [WORD_WIDTH/8-1:0]   bus_strobe;
  logic [WORD_WIDTH-1:0]     bus_rdata;
  logic                      bus_request_stall;
  logic                      bus_error;

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready,
    output bus_ren, bus_wen, bus_addr, bus_wdata, bus_strobe,
    input  bus_rdata, bus_request_stall, bus_error
  );

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready,
    input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_strobe,
    output bus_rdata, bus_request_stall, bus_error
  );
endinterface

// File: rtl/vortex_mem_line_serializer.sv
// Serializes one 512-bit Vortex line request into 16 bus word beats; reads are gathered back
// into a tagged line response, writes skip all-disabled words and return nothing.
module vortex_mem_line_serializer
  import vortex_mem_serializer_pkg::*;
#(
  parameter int LINE_WIDTH     = 512,
  parameter int WORD_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int MEM_TAG_WIDTH  = 56,
  parameter int BUS_ADDR_WIDTH = 32,
  parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                        clk,
  input  logic                        nRST,
  vortex_mem_line_serializer_if.slave io,
  input  logic                        err_clr,
  output logic                        busy,
  output logic                        err_sticky,
  output state_e                      dbg_state
);

  localparam int NBEATS = LINE_WIDTH / WORD_WIDTH;
  localparam int WBYTES = WORD_WIDTH / 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef logic [NBEATS-1:0][WORD_WIDTH-1:0] line_t;
  typedef logic [NBEATS-1:0][WBYTES-1:0]     byteen_t;

  state_e                    state_q, state_d;
  logic [BEAT_W-1:0]         b_q, b_d;
  line_t                     line_q, line_d;
  byteen_t                   be_q, be_d;
  logic [MEM_ADDR_WIDTH-1:0] laddr_q, laddr_d;
  logic [MEM_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                      err_q, err_d;
  logic                      bus_ren_q, bus_ren_d;
  logic                      bus_wen_q, bus_wen_d;
  logic [BUS_ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [WORD_WIDTH-1:0]     bus_wdata_q, bus_wdata_d;
  logic [WBYTES-1:0]         bus_strobe_q, bus_strobe_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      beat_done;
  logic [WBYTES-1:0]         next_nib;

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    line_d    = line_q;
    be_d      = be_q;
    laddr_d   = laddr_q;
    tag_d     = tag_q;
    beat_done = (bus_ren_q | bus_wen_q) & ~io.bus_request_stall;

    case (state_q)
      IDLE: begin
        if (io.mem_req_valid) begin
          laddr_d = io.mem_req_addr;
          tag_d   = io.mem_req_tag;
          b_d     = '0;
          if (io.mem_req_rw) begin
            line_d  = io.mem_req_data;
            be_d    = io.mem_req_byteen;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        // A skipped word (no wen) advances unconditionally; an issued one waits out the stall.
        if (!bus_wen_q || !io.bus_request_stall) begin
          if (b_q == LAST_BEAT) begin
            state_d = IDLE;
            b_d     = '0;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      READ: begin
        if (beat_done) begin
          line_d[b_q] = io.bus_rdata;
          if (b_q == LAST_BEAT) begin
            state_d = RESP;
            b_d     = '0;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      RESP: begin
        if (io.mem_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new error in the same cycle as a clear keeps the flag set.
    if (beat_done && io.bus_error) err_d = 1'b1;
    else if (err_clr)              err_d = 1'b0;
    else                           err_d = err_q;

    // Bus outputs are registered from the next state so they present beat b_d from the next cycle.
    next_nib     = be_d[b_d];
    bus_ren_d    = (state_d == READ);
    bus_wen_d    = (state_d == WRITE) && (|next_nib);
    bus_strobe_d = '0;
    bus_wdata_d  = '0;
    bus_addr_d   = '0;
    if (state_d == READ) begin
      bus_strobe_d = '1;
    end else if (state_d == WRITE) begin
      bus_strobe_d = next_nib;
      bus_wdata_d  = line_d[b_d];
    end
    if (state_d == READ || state_d == WRITE) begin
      bus_addr_d = BUS_ADDR_WIDTH'(beat_addr(BUS_ADDR_W'(BASE_ADDR), laddr_d, b_d));
    end
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      b_q          <= '0;
      line_q       <= '0;
      be_q         <= '0;
      laddr_q      <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      bus_ren_q    <= 1'b0;
      bus_wen_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_strobe_q <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      line_q       <= line_d;
      be_q         <= be_d;
      laddr_q      <= laddr_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      bus_ren_q    <= bus_ren_d;
      bus_wen_q    <= bus_wen_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_strobe_q <= bus_strobe_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign io.mem_req_ready = (state_q == IDLE);
  assign io.mem_rsp_valid = rsp_valid_q;
  assign io.mem_rsp_data  = line_q;
  assign io.mem_rsp_tag   = tag_q;
  assign io.bus_ren       = bus_ren_q;
  assign io.bus_wen       = bus_wen_q;
  assign io.bus_addr      = bus_addr_q;
  assign io.bus_wdata     = bus_wdata_q;
  assign io.bus_strobe    = bus_strobe_q;
  assign busy             = (state_q != IDLE);
  assign err_sticky       = err_q;
  assign dbg_state        = state_q;

endmodule
